// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and default bit period.
// Both the transmitter and the receiver take their BAUD_PER default from here.
package uart_pkg;

    localparam int DATA_W        = 8;
    localparam int BAUD_PER_DFLT = 10416;  // 9600 baud at 100 MHz

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is a parameter
// so the same cell serves idle-high serial lines and idle-low control inputs.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic nrst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) r_sync <= {2{RST_VAL}};
        else         r_sync <= {r_sync[0], d_i};
    end

    assign q_o = r_sync[1];

endmodule

// File: rtl/uartrx_frame.sv
// 8N1 UART receiver with a valid/ready holding register, frame-error and overrun pulses.
// Optional macro UARTRX_MAJORITY_EN: 2-of-3 vote around each mid-bit point, one clock later.
module uartrx_frame
    import uart_pkg::*;
#(
    parameter int BAUD_PER = BAUD_PER_DFLT
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              rx_ser_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic [7:0]        dbg_uartrx_o
);

    localparam int CNT_W = $clog2(BAUD_PER);
`ifdef UARTRX_MAJORITY_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(BAUD_PER / 2 + LAT);
    localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(BAUD_PER - 1);
    localparam logic [3:0]       LAST_BIT = 4'(DATA_W - 1);

    logic              w_rx_sync;
    logic              w_bit;
    uart_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_bitcnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic              r_valid, r_ferr, r_ovr;
    logic              w_cnt_clr, w_sample, w_commit, w_ferr;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .d_i    (rx_ser_i),
        .q_o    (w_rx_sync)
    );

`ifdef UARTRX_MAJORITY_EN
    // Two previous rx_sync samples; with the current one they bracket the bit centre.
    logic [1:0] r_hist;
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) r_hist <= 2'b11;
        else         r_hist <= {r_hist[0], w_rx_sync};
    end
    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_sync) | (r_hist[0] & w_rx_sync);
`else
    assign w_bit = w_rx_sync;
`endif

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_sample    = 1'b0;
        w_commit    = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx_sync) begin
                    w_state_nxt = ST_START;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_START: begin
                if (r_cnt == MID_CNT) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == END_CNT) begin
                    w_cnt_clr = 1'b1;
                    w_sample  = 1'b1;
                    if (r_bitcnt == LAST_BIT) w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_cnt == END_CNT) begin
                    w_cnt_clr = 1'b1;
                    if (w_bit) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (w_rx_sync) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cnt_clr || r_state == ST_IDLE || r_state == ST_BREAK) r_cnt <= '0;
            else                                                       r_cnt <= r_cnt + CNT_W'(1);
            if (r_state == ST_IDLE) r_bitcnt <= '0;
            else if (w_sample)      r_bitcnt <= r_bitcnt + 4'd1;
            if (w_sample) r_shift[r_bitcnt[2:0]] <= w_bit;
        end
    end

    // A consumer accept in the commit cycle frees the register before the new byte lands.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            r_ovr  <= 1'b0;
            if (w_commit && (!r_valid || ready_i)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else begin
                if (w_commit)          r_ovr   <= 1'b1;
                if (r_valid && ready_i) r_valid <= 1'b0;
            end
        end
    end

    assign data_o       = r_data;
    assign valid_o      = r_valid;
    assign frame_err_o  = r_ferr;
    assign overrun_o    = r_ovr;
    assign dbg_uartrx_o = {r_state, r_bitcnt, w_rx_sync};

endmodule

// File: tb/tb_uartrx_frame.sv
// Bench for uartrx_frame at BAUD_PER=16: directed scenarios plus random frames, each frame
// decoded by a line-level reference that samples the driven waveform at the mid-bit points.
`timescale 1ns/1ps
module tb_uartrx_frame;
    import uart_pkg::*;

    localparam int B  = 16;
    localparam int FL = 10 * B;
`ifdef UARTRX_MAJORITY_EN
    localparam int LAT = 1;
    localparam logic [7:0] T7_EXP = 8'hFF;
`else
    localparam int LAT = 0;
    localparam logic [7:0] T7_EXP = 8'hF7;
`endif
    // Two synchroniser stages and the IDLE detection edge precede the receiver latency.
    localparam int LAT_TB   = 3 + B / 2 + 9 * B + 1 + LAT;
    // Waveform sample whose cycle ends at the commit edge.
    localparam int COMMIT_K = LAT_TB - 1;

    typedef enum {K_FALSE, K_FERR, K_OK} kind_e;

    logic       clk_i = 1'b0;
    logic       nrst_i = 1'b0;
    logic       rx_ser_i = 1'b1;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic [7:0] dbg_uartrx_o;

    uartrx_frame #(.BAUD_PER(B)) dut (
        .clk_i        (clk_i),
        .nrst_i       (nrst_i),
        .rx_ser_i     (rx_ser_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .dbg_uartrx_o (dbg_uartrx_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0, n_errors = 0;
    int cyc = 0, start_cyc = 0, rise_cyc = -1;
    int n_ferr = 0, n_ovr = 0, exp_ferr = 0, exp_ovr = 0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic       prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counting and hold-while-valid checks, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (!nrst_i) begin
            prev_valid = 1'b0;
        end else begin
            if (frame_err_o) n_ferr++;
            if (overrun_o)   n_ovr++;
            if (valid_o && !prev_valid) rise_cyc = cyc;
            if (prev_valid && !prev_ready) begin
                check("valid_hold", valid_o, 1'b1);
                check("data_hold", data_o, prev_data);
            end
            prev_valid = valid_o;
            prev_ready = ready_i;
            prev_data  = data_o;
        end
    end

    function automatic logic line_bit(input logic [FL-1:0] w, input int b);
        int p;
        p = b * B + B / 2 + 1;
`ifdef UARTRX_MAJORITY_EN
        return (w[p-1] & w[p]) | (w[p-1] & w[p+1]) | (w[p] & w[p+1]);
`else
        return w[p];
`endif
    endfunction

    task automatic decode(input logic [FL-1:0] w, output kind_e k, output logic [7:0] d);
        d = 8'h00;
        for (int i = 0; i < 8; i++) d[i] = line_bit(w, i + 1);
        if (line_bit(w, 0))      k = K_FALSE;
        else if (!line_bit(w, 9)) k = K_FERR;
        else                      k = K_OK;
    endtask

    task automatic idle(input int n);
        rx_ser_i = 1'b1;
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    // Plays one frame sample per clock; ready_at pulses ready_i on that sample (-1: never).
    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch,
                              input int ready_at, input int cut);
        logic [FL-1:0] w;
        logic          v;
        kind_e         k;
        logic [7:0]    dd;
        for (int b = 0; b < 10; b++) begin
            v = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
            for (int j = 0; j < B; j++) w[b*B+j] = v;
        end
        if (glitch >= 0) w[glitch] = ~w[glitch];
        start_cyc = cyc;
        for (int s = 0; s < cut; s++) begin
            rx_ser_i = w[s];
            ready_i  = (s == ready_at);
            @(posedge clk_i); #1;
        end
        ready_i = 1'b0;
        if (cut == FL) begin
            decode(w, k, dd);
            if (ready_at >= 0) exp_valid = 1'b0;
            if (k == K_OK) begin
                if (!exp_valid) begin exp_valid = 1'b1; exp_data = dd; end
                else exp_ovr++;
            end else if (k == K_FERR) begin
                exp_ferr++;
            end
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_valid"}, valid_o, exp_valid);
        if (exp_valid) check({tag, "_data"}, data_o, exp_data);
        check({tag, "_ferr_cnt"}, n_ferr, exp_ferr);
        check({tag, "_ovr_cnt"}, n_ovr, exp_ovr);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_data"}, data_o, 8'h00);
        check({tag, "_valid"}, valid_o, 1'b0);
        check({tag, "_ferr"}, frame_err_o, 1'b0);
        check({tag, "_ovr"}, overrun_o, 1'b0);
        check({tag, "_dbg"}, dbg_uartrx_o, 8'h01);
    endtask

    task automatic accept(input string tag);
        check({tag, "_acc_valid"}, valid_o, exp_valid);
        if (exp_valid) check({tag, "_acc_data"}, data_o, exp_data);
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i   = 1'b0;
        exp_valid = 1'b0;
        check({tag, "_acc_clear"}, valid_o, 1'b0);
    endtask

    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        @(posedge clk_i); #1;
        check_reset("reset");
        repeat (2) begin @(posedge clk_i); #1; end
        nrst_i = 1'b1;
        idle(5);

        // 1: single byte, held, then accepted
        send_frame(8'hA5, 1'b1, -1, -1, FL);
        check("t1_latency", rise_cyc - start_cyc, LAT_TB);
        check_state("t1");
        idle(20);
        check_state("t1_held");
        accept("t1");

        // 2: short low glitch is a false start
        rx_ser_i = 1'b0;
        repeat (4) begin @(posedge clk_i); #1; end
        idle(3 * B);
        check("t2_state", dbg_uartrx_o[7:5], ST_IDLE);
        check_state("t2");

        // 3: stop bit 0 with the line held low, then a clean frame
        send_frame(8'h3C, 1'b0, -1, -1, FL);
        rx_ser_i = 1'b0;
        repeat (24) begin @(posedge clk_i); #1; end
        check("t3_break", dbg_uartrx_o[7:5], ST_BREAK);
        check_state("t3_err");
        idle(B);
        check("t3_idle", dbg_uartrx_o[7:5], ST_IDLE);
        send_frame(8'h3C, 1'b1, -1, -1, FL);
        check_state("t3_ok");
        accept("t3");

        // 4: back-to-back, second byte overruns
        send_frame(8'h11, 1'b1, -1, -1, FL);
        send_frame(8'h22, 1'b1, -1, -1, FL);
        check_state("t4");
        accept("t4");
        idle(5);
        check("t4_no_22", valid_o, 1'b0);

        // 5: accept in the commit cycle
        send_frame(8'h11, 1'b1, -1, -1, FL);
        send_frame(8'h22, 1'b1, -1, COMMIT_K, FL);
        check_state("t5");
        accept("t5");

        // 6: reset during bit 4 discards the partial byte
        send_frame(8'h77, 1'b1, -1, -1, FL);
        send_frame(8'h5A, 1'b1, -1, -1, 5 * B + B / 2);
        nrst_i   = 1'b0;
        rx_ser_i = 1'b1;
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        #2;
        check_reset("t6_rst");
        @(posedge clk_i); #1;
        nrst_i = 1'b1;
        idle(B);
        send_frame(8'h5A, 1'b1, -1, -1, FL);
        check_state("t6");
        accept("t6");

        // 7: one-cycle low at the centre of bit 3
        send_frame(8'hFF, 1'b1, 4 * B + B / 2 + 1, -1, FL);
        check("t7_data", data_o, T7_EXP);
        check_state("t7");
        accept("t7");

        // Random frames: data, single-sample glitches, commit-cycle accepts, gaps
        for (int r = 0; r < 16; r++) begin
            logic [7:0] d;
            int         g, ra, gap;
            d   = 8'($urandom);
            g   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(B, 9 * B - 1)) : -1;
            ra  = (exp_valid && $urandom_range(0, 3) == 0) ? COMMIT_K : -1;
            send_frame(d, 1'b1, g, ra, FL);
            check_state("rnd");
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                if ($urandom_range(0, 1) == 1) accept("rnd");
                idle(gap * 3);
            end
        end
        idle(5);
        check_state("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
